mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit; consumer of the EX/MEM pipeline register outputs.
- Turns the registered EX/MEM access (address, store data, funct3, memread/memwrite) into a req/ready/rvalid data-memory bus transaction.
- Formats store byte lanes and sign/zero-extends load data.
- Drives o_stall back into the EX/MEM register's stall input until the access completes.

---
 rtl/mem_stage_lsu.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns the registered EX/MEM access into a
// req/ready/rvalid data-memory transaction, formats store lanes, extends
// load data and stalls the upstream pipeline until the access completes.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_flush,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rs2_data_fwd,
    input  logic [2:0]  i_funct3,
    input  logic        i_memread,
    input  logic        i_memwrite,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RDATA,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         bmask_q, bmask_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        ldata_q, ldata_d;
    logic               mis_q, mis_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               access;
    logic               illegal_f3;
    logic               misalign;
    logic               can_start;
    logic               legal_start;
    logic               bad_start;
    logic               timeout_hit;
    logic [3:0]         fmt_bmask;
    logic [31:0]        fmt_wdata;
    logic [31:0]        byte_sh;
    logic [31:0]        half_sh;
    logic [31:0]        ext_data;

    // Start qualification and legality of the access presented by EX/MEM.
    // The bus-error cycle blocks a start so the timed-out instruction can
    // leave EX/MEM instead of being reissued.
    always_comb begin
        access      = i_valid & ~i_flush & (i_memread | i_memwrite);
        illegal_f3  = (i_funct3 == 3'b011) | (i_funct3 == 3'b110) | (i_funct3 == 3'b111);
        misalign    = ((i_funct3[1:0] == 2'b01) & i_alu_result[0]) |
                      ((i_funct3[1:0] == 2'b10) & (i_alu_result[1:0] != 2'b00));
        can_start   = (state_q == S_IDLE) & ~err_q & ~i_reset & access;
        legal_start = can_start & ~illegal_f3 & ~misalign;
        bad_start   = can_start & (illegal_f3 | misalign);
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Store byte-lane formatting; loads always request the full word.
    always_comb begin
        fmt_bmask = 4'b1111;
        fmt_wdata = '0;
        if (i_memwrite) begin
            case (i_funct3[1:0])
                2'b00: begin
                    fmt_bmask = 4'b0001 << i_alu_result[1:0];
                    fmt_wdata = {4{i_rs2_data_fwd[7:0]}};
                end
                2'b01: begin
                    fmt_bmask = i_alu_result[1] ? 4'b1100 : 4'b0011;
                    fmt_wdata = {2{i_rs2_data_fwd[15:0]}};
                end
                default: begin
                    fmt_bmask = 4'b1111;
                    fmt_wdata = i_rs2_data_fwd;
                end
            endcase
        end
    end

    // Load lane extraction and sign/zero extension using the latched size/offset.
    always_comb begin
        byte_sh  = i_dmem_rdata >> {off_q, 3'b000};
        half_sh  = i_dmem_rdata >> {off_q[1], 4'b0000};
        case (f3_q)
            3'b000:  ext_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  ext_data = {24'b0, byte_sh[7:0]};
            3'b001:  ext_data = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  ext_data = {16'b0, half_sh[15:0]};
            default: ext_data = i_dmem_rdata;
        endcase
    end

    // Next-state and registered-output logic for the bus transaction FSM.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bmask_d = bmask_q;
        f3_d    = f3_q;
        off_d   = off_q;
        ldata_d = ldata_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (legal_start) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = i_memwrite;
                    addr_d  = {i_alu_result[31:2], 2'b00};
                    wdata_d = fmt_wdata;
                    bmask_d = fmt_bmask;
                    f3_d    = i_funct3;
                    off_d   = i_alu_result[1:0];
                    cnt_d   = '0;
                end
                mis_d = bad_start;
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_dmem_ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (i_dmem_rvalid) begin
                        ldata_d = ext_data;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_RDATA;
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RDATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_dmem_rvalid) begin
                    ldata_d = ext_data;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            ldata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bmask_q <= bmask_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            ldata_q <= ldata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_bmask = bmask_q;
    assign o_load_data  = ldata_q;
    assign o_done       = (state_q == S_DONE);
    assign o_misaligned = mis_q;
    assign o_bus_err    = err_q;
    assign o_stall      = legal_start | (state_q == S_REQ) | (state_q == S_WAIT_RDATA);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: drivers push expected bus events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage_lsu;

    localparam int unsigned TMO = 8;
    localparam int K_REQ  = 0;
    localparam int K_DONE = 1;
    localparam int K_MIS  = 2;
    localparam int K_ERR  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, flush, mrd, mwr;
    logic [31:0] alu, rs2;
    logic [2:0]  f3;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbmask;
    logic        dready, drvalid;
    logic [31:0] drdata;
    logic        stall;
    logic [31:0] ldata;
    logic        done, mis, berr;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_flush(flush),
        .i_alu_result(alu), .i_rs2_data_fwd(rs2), .i_funct3(f3),
        .i_memread(mrd), .i_memwrite(mwr),
        .o_dmem_req(dreq), .o_dmem_we(dwe), .o_dmem_addr(daddr),
        .o_dmem_wdata(dwdata), .o_dmem_bmask(dbmask),
        .i_dmem_ready(dready), .i_dmem_rvalid(drvalid), .i_dmem_rdata(drdata),
        .o_stall(stall), .o_load_data(ldata), .o_done(done),
        .o_misaligned(mis), .o_bus_err(berr)
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  bmask;
        logic [31:0] wdata;
        logic        is_load;
        logic [31:0] ldata;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    bit          mon_ok;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_cycles = 0;
    int          req_cycles   = 0;
    logic [31:0] last_load = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic take(input int kind, output exp_t e, output bit ok);
        n_checks++;
        ok = 1'b0;
        e  = '{default: '0};
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind) begin
                n_fail++;
                $display("FAIL event_order: got kind %0d, expected kind %0d", kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Reference model, written from the access rules.
    function automatic int unsigned m_size(input logic [2:0] fn);
        return 1 << fn[1:0];
    endfunction

    function automatic bit m_legal(input logic [2:0] fn, input logic [31:0] a);
        if (fn == 3'd3 || fn == 3'd6 || fn == 3'd7) return 1'b0;
        return (a % m_size(fn)) == 0;
    endfunction

    function automatic logic [3:0] m_bmask(input bit store, input logic [2:0] fn, input logic [31:0] a);
        logic [3:0]  bm;
        int unsigned off;
        if (!store) return 4'hF;
        off = a % 4;
        for (int unsigned i = 0; i < 4; i++) bm[i] = (i >= off) && (i < off + m_size(fn));
        return bm;
    endfunction

    function automatic logic [31:0] m_wdata(input bit store, input logic [2:0] fn, input logic [31:0] d);
        if (!store) return '0;
        case (m_size(fn))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, r, mask;
        int unsigned sz;
        sz = m_size(fn);
        if (sz == 4) return rd;
        v    = rd >> (8 * (a % 4));
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        r    = v & mask;
        if (!fn[2] && r[8*sz-1]) r = r | ~mask;
        return r;
    endfunction

    // Monitor: counts stall/req cycles and scores every observable event.
    always @(negedge clk) begin
        if (stall) stall_cycles++;
        if (dreq)  req_cycles++;
        if (!rst) begin
            if (dreq && dready) begin
                take(K_REQ, mon_e, mon_ok);
                if (mon_ok) begin
                    check32("req_addr",  daddr,        mon_e.addr);
                    check32("req_we",    32'(dwe),     32'(mon_e.we));
                    check32("req_bmask", 32'(dbmask),  32'(mon_e.bmask));
                    check32("req_wdata", dwdata,       mon_e.wdata);
                end
            end
            if (done) begin
                take(K_DONE, mon_e, mon_ok);
                if (mon_ok && mon_e.is_load) check32("load_data", ldata, mon_e.ldata);
            end
            if (mis)  take(K_MIS, mon_e, mon_ok);
            if (berr) take(K_ERR, mon_e, mon_ok);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; flush = 1'b0; mrd = 1'b0; mwr = 1'b0;
        dready = 1'b0; drvalid = 1'b0; drdata = $urandom;
    endtask

    task automatic run_access(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d,
                              input logic rd, input logic wr, input int dly, input int rv,
                              input logic [31:0] rdata, input bit flush_w);
        exp_t e;
        bit   store;
        store = wr;
        valid = 1'b1; flush = 1'b0; alu = a; rs2 = d; f3 = fn; mrd = rd; mwr = wr;
        stall_cycles = 0; req_cycles = 0;
        if (!m_legal(fn, a)) begin
            e = '{kind: K_MIS, default: '0};
            sbq.push_back(e);
            #1;
            check32("illegal_no_stall", 32'(stall), 32'd0);
            cycle();
            idle_inputs();
            cycle();
            cycle();
            check32("illegal_stall_cycles", 32'(stall_cycles), 32'd0);
            check32("illegal_req_cycles",   32'(req_cycles),   32'd0);
            return;
        end
        e = '{kind: K_REQ, addr: {a[31:2], 2'b00}, we: store, bmask: m_bmask(store, fn, a),
              wdata: m_wdata(store, fn, d), is_load: 1'b0, ldata: '0};
        sbq.push_back(e);
        e = '{kind: K_DONE, addr: '0, we: 1'b0, bmask: '0, wdata: '0, is_load: !store,
              ldata: store ? last_load : m_load(fn, a, rdata)};
        sbq.push_back(e);
        if (!store) last_load = e.ldata;
        cycle();
        if (flush_w) flush = 1'b1;
        repeat (dly) cycle();
        dready = 1'b1;
        if (!store && rv == 0) begin drvalid = 1'b1; drdata = rdata; end
        cycle();
        dready = 1'b0; drvalid = 1'b0;
        if (!store && rv > 0) begin
            repeat (rv - 1) cycle();
            drvalid = 1'b1; drdata = rdata;
            cycle();
            drvalid = 1'b0;
        end
        idle_inputs();
        cycle();
        check32("stall_cycles", 32'(stall_cycles), 32'(2 + dly + (store ? 0 : rv)));
        check32("req_cycles",   32'(req_cycles),   32'(dly + 1));
    endtask

    task automatic run_nonmem(input bit flushed);
        valid = 1'b1; flush = flushed; mrd = flushed; mwr = 1'b0;
        f3 = 3'd2; alu = '0; rs2 = $urandom;
        stall_cycles = 0; req_cycles = 0;
        cycle();
        cycle();
        idle_inputs();
        check32(flushed ? "flushed_stall" : "nonmem_stall", 32'(stall_cycles), 32'd0);
        check32(flushed ? "flushed_req" : "nonmem_req",     32'(req_cycles),   32'd0);
    endtask

    task automatic run_timeout();
        exp_t e;
        e = '{kind: K_ERR, default: '0};
        sbq.push_back(e);
        valid = 1'b1; flush = 1'b0; alu = 32'h80; rs2 = '0; f3 = 3'd2; mrd = 1'b1; mwr = 1'b0;
        stall_cycles = 0; req_cycles = 0;
        cycle();
        repeat (TMO - 1) cycle();
        check32("tmo_err_early", 32'(berr), 32'd0);
        cycle();
        check32("tmo_err_pulse", 32'(berr),  32'd1);
        check32("tmo_req_drop",  32'(dreq),  32'd0);
        check32("tmo_stall",     32'(stall), 32'd0);
        check32("tmo_req_cycles", 32'(req_cycles), 32'(TMO));
        idle_inputs();
        cycle();
        drvalid = 1'b1; drdata = 32'hCAFE_F00D;
        cycle();
        drvalid = 1'b0;
        cycle();
        check32("late_rvalid_ignored", ldata, last_load);
    endtask

    task automatic run_reset_mid();
        exp_t e;
        e = '{kind: K_REQ, addr: 32'h40, we: 1'b0, bmask: 4'hF, wdata: '0, is_load: 1'b0, ldata: '0};
        sbq.push_back(e);
        valid = 1'b1; flush = 1'b0; alu = 32'h40; f3 = 3'd2; mrd = 1'b1; mwr = 1'b0;
        cycle();
        dready = 1'b1;
        cycle();
        dready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check32("rst_req",   32'(dreq),  32'd0);
        check32("rst_stall", 32'(stall), 32'd0);
        check32("rst_ldata", ldata,      32'd0);
        last_load = '0;
        idle_inputs();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] fn;
        logic [31:0] a;
        logic        wr, rd;
        ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
        rst = 1'b1; alu = '0; rs2 = '0; f3 = '0;
        idle_inputs();
        #12;
        check32("reset_req",   32'(dreq),   32'd0);
        check32("reset_addr",  daddr,       32'd0);
        check32("reset_wdata", dwdata,      32'd0);
        check32("reset_bmask", 32'(dbmask), 32'd0);
        check32("reset_pulses", {28'd0, done, mis, berr, dwe}, 32'd0);
        check32("reset_ldata", ldata,       32'd0);
        check32("reset_stall", 32'(stall),  32'd0);
        cycle();
        rst = 1'b0;
        cycle();

        run_access(3'd2, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1, 0, 32'h0, 1'b0);
        run_access(3'd0, 32'h203, 32'h000000A5, 1'b0, 1'b1, 0, 0, 32'h0, 1'b0);
        run_access(3'd0, 32'h101, 32'h0, 1'b1, 1'b0, 0, 3, 32'h1234F0AB, 1'b0);
        run_access(3'd4, 32'h101, 32'h0, 1'b1, 1'b0, 0, 3, 32'h1234F0AB, 1'b0);
        run_access(3'd5, 32'h102, 32'h0, 1'b1, 1'b0, 1, 0, 32'h1234F0AB, 1'b0);
        run_access(3'd2, 32'h102, 32'h0, 1'b1, 1'b0, 0, 0, 32'h0, 1'b0);
        run_access(3'd3, 32'h000, 32'h0, 1'b1, 1'b0, 0, 0, 32'h0, 1'b0);
        run_timeout();
        run_reset_mid();
        run_access(3'd2, 32'h000, 32'h0, 1'b1, 1'b0, 0, 1, 32'h11223344, 1'b0);
        run_access(3'd1, 32'h202, 32'h0, 1'b1, 1'b0, 1, 2, 32'h8001_7FFE, 1'b1);
        run_access(3'd1, 32'h302, 32'h0000BEEF, 1'b1, 1'b1, 2, 0, 32'h0, 1'b0);
        run_nonmem(1'b0);
        run_nonmem(1'b1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom % 10)
                0: run_nonmem(1'b0);
                1: run_nonmem(1'b1);
                default: begin
                    wr = 1'($urandom % 2);
                    rd = wr ? 1'($urandom % 2) : 1'b1;
                    if ($urandom % 8 == 0) begin
                        fn = ($urandom % 2 == 0) ? 3'd3 : (($urandom % 2 == 0) ? 3'd6 : 3'd7);
                    end else if (wr) begin
                        fn = 3'($urandom % 3);
                    end else begin
                        fn = ld_f3[$urandom % 5];
                    end
                    a = $urandom;
                    if ($urandom % 2 == 0) a[1:0] = 2'b00;
                    run_access(fn, a, $urandom, rd, wr, int'($urandom % 4), int'($urandom % 4),
                               $urandom, ($urandom % 4) == 0);
                end
            endcase
        end

        cycle();
        check32("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
